// File: rtl/ahblite_busmatrix_inputstage_sub.sv
// AHB-Lite bus-matrix input stage: holds a master address phase until the output stage grants it.
// Optional BUSMATRIX_SEQ2NONSEQ_EN turns a held SEQ into NONSEQ toward the output stage.
module ahblite_busmatrix_inputstage_sub (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HREADY,
  input  logic        ACTIVE_SUB,
  input  logic        OS_HREADY,
  input  logic        HREADYOUT_SUB,
  input  logic        HRESP_SUB,
  output logic        HSEL_SUB,
  output logic [31:0] HADDR_SUB,
  output logic [1:0]  HTRANS_SUB,
  output logic        HWRITE_SUB,
  output logic [2:0]  HSIZE_SUB,
  output logic [2:0]  HBURST_SUB,
  output logic [3:0]  HPROT_SUB,
  output logic        TRANS_HOLD_SUB,
  output logic        HREADYOUT,
  output logic        HRESP
);

  logic        new_trans;
  logic        accept;
  logic        capture;
  logic        pend_q, pend_d;
  logic        data_phase_q, data_phase_d;

  logic        hsel_q;
  logic [31:0] haddr_q;
  logic [1:0]  htrans_q;
  logic        hwrite_q;
  logic [2:0]  hsize_q;
  logic [2:0]  hburst_q;
  logic [3:0]  hprot_q;
  logic [1:0]  held_htrans;

  always_comb begin
    new_trans      = HSEL & HTRANS[1] & HREADY;
    TRANS_HOLD_SUB = new_trans | pend_q;
    accept         = TRANS_HOLD_SUB & ACTIVE_SUB & OS_HREADY;
    capture        = new_trans & ~accept;
  end

  // pend and new_trans are mutually exclusive: HREADYOUT is low while pend is set.
  always_comb begin
    pend_d = pend_q;
    if (accept) begin
      pend_d = 1'b0;
    end else if (new_trans) begin
      pend_d = 1'b1;
    end
  end

  // data_phase only advances when the current slave data phase completes (or none is owned).
  always_comb begin
    data_phase_d = data_phase_q;
    if (OS_HREADY || !data_phase_q) begin
      data_phase_d = accept;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_q       <= 1'b0;
      data_phase_q <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      data_phase_q <= data_phase_d;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hsel_q   <= 1'b0;
      haddr_q  <= 32'h0;
      htrans_q <= 2'b00;
      hwrite_q <= 1'b0;
      hsize_q  <= 3'b000;
      hburst_q <= 3'b000;
      hprot_q  <= 4'h0;
    end else if (capture) begin
      hsel_q   <= HSEL;
      haddr_q  <= HADDR;
      htrans_q <= HTRANS;
      hwrite_q <= HWRITE;
      hsize_q  <= HSIZE;
      hburst_q <= HBURST;
      hprot_q  <= HPROT;
    end
  end

`ifdef BUSMATRIX_SEQ2NONSEQ_EN
  // A held SEQ may land after another master broke the burst, so restart it as NONSEQ.
  always_comb begin
    held_htrans = htrans_q;
    if (htrans_q == 2'b11) begin
      held_htrans = 2'b10;
    end
  end
`else
  always_comb begin
    held_htrans = htrans_q;
  end
`endif

  always_comb begin
    if (pend_q) begin
      HSEL_SUB   = hsel_q;
      HADDR_SUB  = haddr_q;
      HTRANS_SUB = held_htrans;
      HWRITE_SUB = hwrite_q;
      HSIZE_SUB  = hsize_q;
      HBURST_SUB = hburst_q;
      HPROT_SUB  = hprot_q;
    end else begin
      HSEL_SUB   = new_trans;
      HADDR_SUB  = HADDR;
      HTRANS_SUB = new_trans ? HTRANS : 2'b00;
      HWRITE_SUB = HWRITE;
      HSIZE_SUB  = HSIZE;
      HBURST_SUB = HBURST;
      HPROT_SUB  = HPROT;
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    if (pend_q) begin
      HREADYOUT = 1'b0;
    end else if (data_phase_q) begin
      HREADYOUT = HREADYOUT_SUB;
    end
    HRESP = data_phase_q & HRESP_SUB;
  end

endmodule
